// File: rtl/cache_control_i.sv
// rtl/cache_control_i.sv - control FSM and performance counters for the 2-way read-only instruction cache
module cache_control_i #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 hit,
  input  logic                 pmem_resp,
  input  logic                 perf_clear,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 sel_way_mux,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       hit_event;
  logic       miss_event;
  logic       stall_event;

  always_comb begin
    next_state  = state;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    sel_way_mux = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read) begin
          if (hit) mem_resp = 1'b1;
          else     next_state = FETCH;
        end
      end
      FETCH: begin
        pmem_read   = 1'b1;
        sel_way_mux = 1'b1;
        if (pmem_resp) next_state = RESPOND;
      end
      RESPOND: begin
        // A miss here means the refill did not land; IDLE re-treats it as a new miss.
        mem_resp   = mem_read & hit;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  assign hit_event   = (state == IDLE) & mem_read & hit;
  assign miss_event  = (state == IDLE) & mem_read & ~hit;
  assign stall_event = mem_read & ~mem_resp;

  // Counters saturate at all-ones; perf_clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset || perf_clear) begin
      hit_count   <= '0;
      miss_count  <= '0;
      stall_count <= '0;
    end else begin
      if (hit_event && !(&hit_count))     hit_count   <= hit_count + 1'b1;
      if (miss_event && !(&miss_count))   miss_count  <= miss_count + 1'b1;
      if (stall_event && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_control_i.sv
// tb/tb_cache_control_i.sv - scoreboard bench for cache_control_i
module tb_cache_control_i;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_read = 1'b0;
  logic          hit = 1'b0;
  logic          pmem_resp = 1'b0;
  logic          perf_clear = 1'b0;
  logic          mem_resp;
  logic          pmem_read;
  logic          sel_way_mux;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] stall_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];
  int mon_e;

  cache_control_i #(.CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .hit(hit),
    .pmem_resp(pmem_resp),
    .perf_clear(perf_clear),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read),
    .sel_way_mux(sel_way_mux),
    .hit_count(hit_count),
    .miss_count(miss_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every mem_resp must match the cycle the stimulus predicted for it.
  always @(negedge clk) begin
    if (mem_resp === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mem_resp_unexpected: got pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          fails++;
          $display("FAIL mem_resp_cycle: got cycle %0d, required cycle %0d", cyc, mon_e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic mr, input logic h,
                       input logic pr, input logic pc);
    @(posedge clk);
    #1;
    reset      = rst_n;
    mem_read   = mr;
    hit        = h;
    pmem_resp  = pr;
    perf_clear = pc;
    #1;
  endtask

  task automatic check_counts(input string name, input int h, input int m, input int s);
    check({name, "_hit"},   32'(hit_count),   32'(h));
    check({name, "_miss"},  32'(miss_count),  32'(m));
    check({name, "_stall"}, 32'(stall_count), 32'(s));
  endtask

  initial begin
    // Reset, then a zero-wait hit
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check_counts("reset", 0, 0, 0);
    check("reset_pmem_read", 32'(pmem_read), 0);
    check("reset_sel", 32'(sel_way_mux), 0);
    drive(1, 1, 1, 0, 0);
    exp_q.push_back(cyc);
    drive(1, 0, 0, 0, 1);
    check_counts("first_hit", 1, 0, 0);

    // Miss with pmem_resp on the third FETCH cycle
    drive(1, 1, 0, 0, 0);
    check("miss_c1_pmem_read", 32'(pmem_read), 0);
    check_counts("after_clear", 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    check("miss_c2_pmem_read", 32'(pmem_read), 1);
    check("miss_c2_sel", 32'(sel_way_mux), 1);
    drive(1, 1, 0, 0, 0);
    check("miss_c3_pmem_read", 32'(pmem_read), 1);
    check("miss_c3_sel", 32'(sel_way_mux), 1);
    drive(1, 1, 0, 1, 0);
    check("miss_c4_pmem_read", 32'(pmem_read), 1);
    check("miss_c4_sel", 32'(sel_way_mux), 1);
    drive(1, 1, 1, 0, 0);
    exp_q.push_back(cyc);
    check("miss_c5_pmem_read", 32'(pmem_read), 0);
    check("miss_c5_sel", 32'(sel_way_mux), 0);
    drive(1, 0, 0, 0, 0);
    check_counts("miss", 0, 1, 4);
    check("miss_idle_pmem_read", 32'(pmem_read), 0);

    // Abort: mem_read drops after the first FETCH cycle
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("abort_f1_pmem_read", 32'(pmem_read), 1);
    drive(1, 0, 0, 0, 0);
    check("abort_f2_pmem_read", 32'(pmem_read), 1);
    drive(1, 0, 0, 1, 0);
    check("abort_f3_pmem_read", 32'(pmem_read), 1);
    drive(1, 0, 1, 0, 0);
    check("abort_respond_pmem_read", 32'(pmem_read), 0);
    drive(1, 1, 1, 0, 0);
    exp_q.push_back(cyc);
    check("abort_miss_count", 32'(miss_count), 2);
    drive(1, 0, 0, 0, 0);
    check("abort_then_hit", 32'(hit_count), 1);

    // Reset mid-FETCH, then a stray pmem_resp
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("rstfetch_pmem_read_before", 32'(pmem_read), 1);
    drive(1, 0, 0, 0, 0);
    check("rstfetch_pmem_read_after", 32'(pmem_read), 0);
    check_counts("rstfetch", 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    check("stray_pmem_read", 32'(pmem_read), 0);
    drive(1, 1, 1, 0, 0);
    exp_q.push_back(cyc);
    check("stray_pmem_read_next", 32'(pmem_read), 0);
    check("stray_sel", 32'(sel_way_mux), 0);
    drive(1, 0, 0, 0, 0);
    check("stray_then_hit", 32'(hit_count), 1);

    // Saturation: 20 hits on a 4-bit counter, then clear with a concurrent hit
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 0, 0);
      exp_q.push_back(cyc);
    end
    drive(1, 1, 1, 0, 1);
    exp_q.push_back(cyc);
    check("sat_hit_count", 32'(hit_count), 15);
    drive(1, 0, 0, 0, 0);
    check_counts("clear_with_hit", 0, 0, 0);

    // Refill fault: hit stays low in RESPOND
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    check("fault_respond_pmem_read", 32'(pmem_read), 0);
    drive(1, 1, 0, 0, 0);
    check("fault_idle_pmem_read", 32'(pmem_read), 0);
    drive(1, 1, 0, 1, 0);
    check("fault_refetch_pmem_read", 32'(pmem_read), 1);
    check("fault_miss_count", 32'(miss_count), 2);
    drive(1, 1, 1, 0, 0);
    exp_q.push_back(cyc);
    check("fault_stall_count", 32'(stall_count), 6);
    drive(1, 0, 0, 0, 0);
    check_counts("fault_end", 0, 2, 6);

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("pending_responses", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_control_i.md
Name: cache_control_i

Overview:
- Control FSM for the 2-way, read-only instruction cache datapath.
- Turns CPU fetch requests into same-cycle hit responses, or into a physical-memory refill followed by a response.
- Drives pmem_read, mem_resp and the datapath's way-select mux (sel_way_mux).
- Keeps saturating hit, miss and stall counters for performance monitoring.
- Sits between the pipeline's IF stage, cache_datapath_i and the physical-memory arbiter.

Parameters:
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- mem_read  input  1  CPU fetch request; held high until mem_resp.
- hit  input  1  datapath tag-match-and-valid for the current mem_address.
- pmem_resp  input  1  physical memory has returned the block; one-cycle pulse.
- perf_clear  input  1  synchronous clear of all counters.
- mem_resp  output  1  fetch complete; mem_rdata is valid this cycle.
- pmem_read  output  1  block read request to physical memory.
- sel_way_mux  output  1  0 selects the hit way; 1 selects the LRU victim way for refill.
- hit_count  output  CNT_WIDTH  requests serviced without a refill.
- miss_count  output  CNT_WIDTH  requests that triggered a refill.
- stall_count  output  CNT_WIDTH  cycles with mem_read=1 and mem_resp=0.

Behaviour:
- Reset (reset=0 at clk edge):
  - State goes to IDLE; all counters go to 0.
  - Outputs settle to mem_resp=0, pmem_read=0, sel_way_mux=0.
  - Reset wins over every other event, including mid-FETCH. pmem_read drops the next cycle and the outstanding pmem_resp is ignored.
- Outputs are Moore-decoded per state, except mem_resp, which is a Mealy output in IDLE and RESPOND.
- IDLE:
  - sel_way_mux=0, pmem_read=0.
  - mem_read=1 and hit=1: mem_resp=1 in the same cycle (zero-wait hit); hit_count+1; stay in IDLE.
  - mem_read=1 and hit=0: mem_resp=0; miss_count+1; go to FETCH.
  - mem_read=0: no action.
- FETCH:
  - pmem_read=1, sel_way_mux=1, mem_resp=0.
  - The datapath loads the victim way in the cycle where pmem_read and pmem_resp are both high.
  - pmem_resp=1: go to RESPOND. Otherwise stay in FETCH, with no timeout.
- RESPOND:
  - pmem_read=0, sel_way_mux=0.
  - mem_resp = mem_read & hit. Not counted as a hit. Always return to IDLE.
  - If hit=0 here, the refill failed (a fault condition). mem_resp=0, and the request is re-evaluated in IDLE as a new miss.
- Request abort: if mem_read drops during FETCH, the refill still completes and RESPOND issues no mem_resp. No partial fill ever occurs.
- Latency:
  - Hit: 0 cycles (mem_resp in the request cycle).
  - Miss: N+1 cycles, where N is the number of FETCH cycles including the pmem_resp cycle.
- Counters:
  - Unsigned, saturating at 2^CNT_WIDTH-1 with no wrap.
  - stall_count increments every cycle with mem_read & ~mem_resp, including the IDLE miss-detect cycle.
  - perf_clear=1 zeroes all three counters on the edge and overrides any increment in that cycle.
  - Counters are registered outputs, so an increment is visible the cycle after the event.
- pmem_resp arriving outside FETCH is ignored.
- States: IDLE=0, FETCH=1, RESPOND=2, encoded in 2 bits. The unused encoding recovers to IDLE.

Test Plan:
- Reset then hit: reset=0 for 2 cycles, release, then mem_read=1, hit=1. Required: mem_resp=1 in the same cycle; next cycle hit_count=1, miss_count=0, stall_count=0.
- Miss with 3-cycle memory: mem_read=1, hit=0, pmem_resp pulsed on the 3rd FETCH cycle, hit=1 in RESPOND. Required: pmem_read=1 and sel_way_mux=1 for exactly 3 cycles; mem_resp in RESPOND (cycle 5 from request); miss_count=1, hit_count=0, stall_count=4.
- Abort mid-fetch: miss starts, then mem_read=0 after 1 FETCH cycle, then pmem_resp. Required: pmem_read held until pmem_resp; no mem_resp pulse; state back to IDLE; miss_count=1.
- Reset mid-FETCH: reset=0 while pmem_read=1. Required: next cycle pmem_read=0, state IDLE, all counters 0. A following stray pmem_resp causes no state change.
- Saturation and clear: CNT_WIDTH=4, 20 back-to-back hits. Required: hit_count stops at 15. Then perf_clear=1 with a concurrent hit: required hit_count=0 next cycle.
- Refill fault: hit=0 held in RESPOND. Required: no mem_resp; return to IDLE; re-enter FETCH next cycle; miss_count=2.
